// File: rtl/sb_ctrl_if.sv
// rtl/sb_ctrl_if.sv - Store-buffer controller handshake bundle (dispatch, execute, retire, drain)
// Optional SB_STALL_CNT_EN adds the allocation stall counter output.
interface sb_ctrl_if #(
   parameter int SB_ENTRY = 8,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32
);
   localparam int NW = $clog2(SB_ENTRY);

   logic                alloc_v_i;
   logic                alloc_ready_o;
   logic [NW-1:0]       alloc_sb_num_o;
   logic                st_wb_v_i;
   logic [NW-1:0]       st_wb_sb_num_i;
   logic [ADDR_W-1:0]   st_wb_addr_i;
   logic [DATA_W-1:0]   st_wb_data_i;
   logic                st_retire_v_i;
   logic                flush_i;
   logic                mem_v_o;
   logic [ADDR_W-1:0]   mem_addr_o;
   logic [DATA_W-1:0]   mem_data_o;
   logic                mem_ready_i;
   logic [SB_ENTRY-1:0] sb_wb_vector_o;
   logic [NW-1:0]       sb_commit_pt_o;
   logic                sb_full_o;
   logic                sb_empty_o;
`ifdef SB_STALL_CNT_EN
   logic [31:0]         sb_stall_cnt_o;
`endif

   modport slave (
`ifdef SB_STALL_CNT_EN
      output sb_stall_cnt_o,
`endif
      input  alloc_v_i, st_wb_v_i, st_wb_sb_num_i, st_wb_addr_i, st_wb_data_i,
      input  st_retire_v_i, flush_i, mem_ready_i,
      output alloc_ready_o, alloc_sb_num_o, mem_v_o, mem_addr_o, mem_data_o,
      output sb_wb_vector_o, sb_commit_pt_o, sb_full_o, sb_empty_o
   );

   modport master (
`ifdef SB_STALL_CNT_EN
      input  sb_stall_cnt_o,
`endif
      output alloc_v_i, st_wb_v_i, st_wb_sb_num_i, st_wb_addr_i, st_wb_data_i,
      output st_retire_v_i, flush_i, mem_ready_i,
      input  alloc_ready_o, alloc_sb_num_o, mem_v_o, mem_addr_o, mem_data_o,
      input  sb_wb_vector_o, sb_commit_pt_o, sb_full_o, sb_empty_o
   );
endinterface

// File: rtl/sb_ctrl.sv
// rtl/sb_ctrl.sv - Store-buffer controller: allocate, capture, retire and in-order drain
// Optional SB_STALL_CNT_EN adds a saturating count of refused allocation cycles.
module sb_ctrl #(
   parameter int SB_ENTRY = 8,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32
) (
   input logic      clk_i,
   input logic      reset_n_i,
   sb_ctrl_if.slave sb
);
   localparam int NW = $clog2(SB_ENTRY);
   localparam int CW = NW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(SB_ENTRY);

   typedef enum logic {IDLE, REQ} drain_state_t;

   logic [ADDR_W-1:0]   addr_mem [SB_ENTRY];
   logic [DATA_W-1:0]   data_mem [SB_ENTRY];
   logic [SB_ENTRY-1:0] wb_q;
   logic [SB_ENTRY-1:0] wb_d;
   logic [NW-1:0]       head_q;
   logic [NW-1:0]       retire_q;
   logic [NW-1:0]       tail_q;
   logic [NW-1:0]       retire_d;
   logic [CW-1:0]       count_q;
   logic [CW-1:0]       ret_cnt_q;
   logic [CW-1:0]       count_d;
   logic [CW-1:0]       ret_cnt_d;
   logic [CW-1:0]       unret_left;
   logic [SB_ENTRY-1:0] alloc_mask;
   logic [SB_ENTRY-1:0] squash_mask;
   logic                full;
   logic                alloc_ok;
   logic                retire_ok;
   logic                drain_done;
   logic                wb_ok;
   drain_state_t        state_q;
   logic                mem_v_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_data_q;

   // ret_cnt_q counts retired-but-undrained entries, so a completely full buffer
   // (retire_ptr == tail) can still tell "all unretired" from "all retired".
   assign full       = (count_q == FULL_CNT);
   assign alloc_ok   = sb.alloc_v_i && !full && !sb.flush_i;
   assign drain_done = (state_q == REQ) && sb.mem_ready_i;
   assign retire_ok  = sb.st_retire_v_i && (count_q != ret_cnt_q) && wb_q[retire_q];
   assign retire_d   = retire_q + NW'(retire_ok);
   assign ret_cnt_d  = ret_cnt_q + CW'(retire_ok) - CW'(drain_done);
   assign unret_left = count_q - ret_cnt_q - CW'(retire_ok);

   for (genvar g = 0; g < SB_ENTRY; g++) begin : g_mask
      logic [NW-1:0] off_head;
      logic [NW-1:0] off_ret;
      assign off_head       = NW'(g) - head_q;
      assign off_ret        = NW'(g) - retire_d;
      assign alloc_mask[g]  = ({1'b0, off_head} < count_q);
      assign squash_mask[g] = sb.flush_i && ({1'b0, off_ret} < unret_left);
   end

   assign wb_ok = sb.st_wb_v_i && alloc_mask[sb.st_wb_sb_num_i]
                  && !squash_mask[sb.st_wb_sb_num_i];

   always_comb begin
      wb_d = wb_q;
      if (wb_ok) begin
         wb_d[sb.st_wb_sb_num_i] = 1'b1;
      end
      if (drain_done) begin
         wb_d[head_q] = 1'b0;
      end
      if (alloc_ok) begin
         wb_d[tail_q] = 1'b0;
      end
      wb_d = wb_d & ~squash_mask;
   end

   assign count_d = sb.flush_i ? ret_cnt_d
                               : count_q + CW'(alloc_ok) - CW'(drain_done);

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         head_q    <= '0;
         retire_q  <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         ret_cnt_q <= '0;
         wb_q      <= '0;
      end else begin
         head_q    <= head_q + NW'(drain_done);
         retire_q  <= retire_d;
         tail_q    <= sb.flush_i ? retire_d : tail_q + NW'(alloc_ok);
         count_q   <= count_d;
         ret_cnt_q <= ret_cnt_d;
         wb_q      <= wb_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wb_ok) begin
         addr_mem[sb.st_wb_sb_num_i] <= sb.st_wb_addr_i;
         data_mem[sb.st_wb_sb_num_i] <= sb.st_wb_data_i;
      end
   end

   // A completed request always returns to IDLE, leaving one idle cycle between drains.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q    <= IDLE;
         mem_v_q    <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ret_cnt_q != '0) begin
                  state_q    <= REQ;
                  mem_v_q    <= 1'b1;
                  mem_addr_q <= addr_mem[head_q];
                  mem_data_q <= data_mem[head_q];
               end
            end
            REQ: begin
               if (sb.mem_ready_i) begin
                  state_q <= IDLE;
                  mem_v_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               mem_v_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef SB_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         stall_cnt_q <= '0;
      end else if (sb.alloc_v_i && full && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign sb.sb_stall_cnt_o = stall_cnt_q;
`endif

   assign sb.alloc_ready_o  = !full;
   assign sb.alloc_sb_num_o = tail_q;
   assign sb.mem_v_o        = mem_v_q;
   assign sb.mem_addr_o     = mem_addr_q;
   assign sb.mem_data_o     = mem_data_q;
   assign sb.sb_wb_vector_o = wb_q;
   assign sb.sb_commit_pt_o = head_q;
   assign sb.sb_full_o      = full;
   assign sb.sb_empty_o     = (count_q == '0);
endmodule

// File: tb/tb_sb_ctrl.sv
// tb/tb_sb_ctrl.sv - Scoreboard bench for sb_ctrl against a queue-based store-buffer model
module tb_sb_ctrl;
   localparam int N = 8;

   typedef struct {
      int          num;
      bit          wb;
      bit          ret;
      logic [31:0] addr;
      logic [31:0] data;
   } ent_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } drain_t;

   logic clk = 1'b0;
   logic reset_n;
   int   n_tests = 0;
   int   n_fail = 0;

   ent_t   ents[$];
   drain_t exp_q[$];
   int     m_head;
   bit     m_mv;
   bit     armed = 1'b0;
   longint m_stall;

   int     nret, n0, wn_r;
   bit     mfull, done, ret_ok;
   ent_t   ne;
   drain_t de, got;
   logic [7:0] wbv;
   bit          prev_hold = 1'b0;
   logic [31:0] prev_addr, prev_data;

   sb_ctrl_if #(.SB_ENTRY(N), .ADDR_W(32), .DATA_W(32)) ifc ();

   sb_ctrl #(.SB_ENTRY(N), .ADDR_W(32), .DATA_W(32)) dut (
      .clk_i    (clk),
      .reset_n_i(reset_n),
      .sb       (ifc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the buffer is an ordered list of live stores, oldest first.
   always @(posedge clk) begin
      if (!reset_n) begin
         ents.delete();
         exp_q.delete();
         m_head  = 0;
         m_mv    = 1'b0;
         m_stall = 0;
         armed   = 1'b1;
      end else begin
         nret = 0;
         foreach (ents[k]) if (ents[k].ret) nret++;
         n0     = nret;
         mfull  = (ents.size() == N);
         done   = m_mv && ifc.mem_ready_i;
         ret_ok = ifc.st_retire_v_i && (nret < ents.size()) && ents[nret].wb;
         if (ifc.st_wb_v_i) begin
            foreach (ents[k]) begin
               if (ents[k].num == int'(ifc.st_wb_sb_num_i)
                   && !(ifc.flush_i && k >= nret + int'(ret_ok))) begin
                  ents[k].wb   = 1'b1;
                  ents[k].addr = ifc.st_wb_addr_i;
                  ents[k].data = ifc.st_wb_data_i;
               end
            end
         end
         if (ret_ok) begin
            ents[nret].ret = 1'b1;
            de.addr = ents[nret].addr;
            de.data = ents[nret].data;
            exp_q.push_back(de);
            nret++;
         end
         if (ifc.alloc_v_i && mfull && m_stall < 64'hFFFF_FFFF) m_stall++;
         if (done) begin
            void'(ents.pop_front());
            m_head = (m_head + 1) % N;
            nret--;
            m_mv = 1'b0;
         end else if (!m_mv && n0 > 0) begin
            m_mv = 1'b1;
         end
         if (ifc.flush_i) begin
            while (ents.size() > nret) void'(ents.pop_back());
         end else if (ifc.alloc_v_i && !mfull) begin
            ne.num  = (m_head + ents.size()) % N;
            ne.wb   = 1'b0;
            ne.ret  = 1'b0;
            ne.addr = '0;
            ne.data = '0;
            ents.push_back(ne);
         end
      end
   end

   // Monitor: state outputs against the model, drain handshakes against the scoreboard.
   always @(negedge clk) begin
      if (armed) begin
         wbv = '0;
         foreach (ents[k]) if (ents[k].wb) wbv[ents[k].num] = 1'b1;
         chk("alloc_ready", 64'(ifc.alloc_ready_o), 64'(ents.size() != N));
         chk("alloc_sb_num", 64'(ifc.alloc_sb_num_o), 64'((m_head + ents.size()) % N));
         chk("commit_pt", 64'(ifc.sb_commit_pt_o), 64'(m_head));
         chk("full", 64'(ifc.sb_full_o), 64'(ents.size() == N));
         chk("empty", 64'(ifc.sb_empty_o), 64'(ents.size() == 0));
         chk("wb_vector", 64'(ifc.sb_wb_vector_o), 64'(wbv));
         chk("mem_v", 64'(ifc.mem_v_o), 64'(m_mv));
`ifdef SB_STALL_CNT_EN
         chk("stall_cnt", 64'(ifc.sb_stall_cnt_o), 64'(m_stall));
`endif
         if (reset_n && prev_hold) begin
            chk("hold_addr", 64'(ifc.mem_addr_o), 64'(prev_addr));
            chk("hold_data", 64'(ifc.mem_data_o), 64'(prev_data));
         end
         if (reset_n && ifc.mem_v_o && ifc.mem_ready_i) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL drain_unexpected: got addr %0h with no retired store pending",
                        ifc.mem_addr_o);
            end else begin
               got = exp_q.pop_front();
               chk("drain_addr", 64'(ifc.mem_addr_o), 64'(got.addr));
               chk("drain_data", 64'(ifc.mem_data_o), 64'(got.data));
            end
         end
         prev_hold = reset_n && ifc.mem_v_o && !ifc.mem_ready_i;
         prev_addr = ifc.mem_addr_o;
         prev_data = ifc.mem_data_o;
      end
   end

   task automatic cyc(input bit a, input bit w, input int wn, input logic [31:0] wa,
                      input logic [31:0] wd, input bit r, input bit f, input bit rdy);
      ifc.alloc_v_i      = a;
      ifc.st_wb_v_i      = w;
      ifc.st_wb_sb_num_i = 3'(wn);
      ifc.st_wb_addr_i   = wa;
      ifc.st_wb_data_i   = wd;
      ifc.st_retire_v_i  = r;
      ifc.flush_i        = f;
      ifc.mem_ready_i    = rdy;
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b1;
      chk("rst_empty", 64'(ifc.sb_empty_o), 64'd1);
      chk("rst_mem_v", 64'(ifc.mem_v_o), 64'd0);
      repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0);

      repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 32'h100, 32'hAA, 0, 0, 0);
      chk("tp_wb_vec", 64'(ifc.sb_wb_vector_o), 64'h02);
      cyc(0, 1, 0, 32'h200, 32'hB0, 0, 0, 0);
      cyc(0, 1, 2, 32'h300, 32'hB2, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 1);
      cyc(0, 0, 0, 0, 0, 1, 0, 1);
      repeat (6) cyc(0, 0, 0, 0, 0, 0, 0, 1);
      chk("tp_commit_end", 64'(ifc.sb_commit_pt_o), 64'd2);

      do_reset();
      repeat (10) cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("tp_full", 64'(ifc.sb_full_o), 64'd1);
      chk("tp_not_ready", 64'(ifc.alloc_ready_o), 64'd0);
      cyc(1, 1, 0, 32'h400, 32'hC0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 1, 0, 0);
      repeat (6) cyc(1, 0, 0, 0, 0, 0, 0, 1);

      do_reset();
      repeat (5) cyc(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1, i, 32'h1000 + i, 32'h50 + i, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 1, 0);
      chk("tp_flush_tail", 64'(ifc.alloc_sb_num_o), 64'd2);
      chk("tp_flush_wbv", 64'(ifc.sb_wb_vector_o), 64'h03);
      repeat (6) cyc(0, 0, 0, 0, 0, 0, 0, 1);

      do_reset();
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 32'h44, 32'h99, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      repeat (7) cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("tp_req_held", 64'(ifc.mem_v_o), 64'd1);
      reset_n = 1'b0;
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("tp_rst_mem_v", 64'(ifc.mem_v_o), 64'd0);
      chk("tp_rst_addr", 64'(ifc.mem_addr_o), 64'd0);
      reset_n = 1'b1;
      cyc(0, 0, 0, 0, 0, 0, 0, 1);

      for (int c = 0; c < 4000; c++) begin
         bit a, w, r, f, rdy;
         a    = ($urandom_range(0, 99) < 60);
         r    = ($urandom_range(0, 99) < 40);
         f    = ($urandom_range(0, 99) < 3);
         rdy  = ($urandom_range(0, 99) < 65);
         w    = ($urandom_range(0, 99) < 60);
         wn_r = $urandom_range(0, N - 1);
         foreach (ents[k]) if (ents[k].num == wn_r && ents[k].ret) w = 1'b0;
         if ($urandom_range(0, 999) == 0) reset_n = 1'b0;
         cyc(a, w, wn_r, $urandom, $urandom, r, f, rdy);
         reset_n = 1'b1;
      end
      repeat (20) cyc(0, 0, 0, 0, 0, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
